// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Brief   : MEM-stage load/store responder with configurable wait states.
//           Optional misalignment check enabled by MEM_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         C_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic [DATA_W-1:0]       r_mem [0:C_DEPTH-1];
    logic                    w_accept;
    logic                    w_access;
    logic                    w_misalign;
    logic                    w_unused_addr;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] r_addr_lo;
    logic       r_err;

    assign w_misalign    = (r_addr_lo != 2'b00);
    assign w_unused_addr = ^req_addr[31:DEPTH_LOG2+2];
    assign rsp_err       = r_err;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_addr_lo <= 2'b00;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) r_addr_lo <= req_addr[1:0];
            if (w_access) r_err     <= w_misalign;
        end
    end
`else
    assign w_misalign    = 1'b0;
    assign w_unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
    assign rsp_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= C_WAIT;
                r_we    <= req_we;
                r_idx   <= req_addr[DEPTH_LOG2+1:2];
                r_wdata <= req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Stores and rejected accesses report zero data.
            if (w_access) begin
                r_rdata <= (r_we || w_misalign) ? '0 : r_mem[r_idx];
            end
        end
    end

    // Array is not reset; the write is gated by state so a reset abort drops it.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_misalign) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire
